// File: rtl/grid_pkg.sv
// Shared constants and types for the grid memory port-A arbiter.
package grid_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 256;

    localparam int unsigned GC      = 0;
    localparam int unsigned LC      = 1;
    localparam int unsigned DBG     = 2;
    localparam int unsigned NUM_REQ = 3;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StOwnGc,
        StOwnLc,
        StOwnDbg
    } arb_state_e;

endpackage

// File: rtl/grid_clear_seq.sv
// Walks the grid address space once, one word per cycle, to zero the memory.
module grid_clear_seq #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    assign busy_o = busy_q;
    assign addr_o = cnt_q;
    assign last_o = busy_q && (cnt_q == LastAddr);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q) begin
            if (last_o) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Reset leaves the sequencer running so the grid is cleared on power-up.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/grid_port_arbiter.sv
// Port-A owner for the grid memory: clear sequencer plus a locking arbiter for
// the game controller, line-clear engine and debug loader.
module grid_port_arbiter
    import grid_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_start,
    output logic              clear_busy,
    input  logic              req_gc,
    input  logic              req_lc,
    input  logic              req_dbg,
    input  logic [ADDR_W-1:0] addr_gc,
    input  logic [ADDR_W-1:0] addr_lc,
    input  logic [ADDR_W-1:0] addr_dbg,
    input  logic [DATA_W-1:0] wdata_gc,
    input  logic [DATA_W-1:0] wdata_lc,
    input  logic [DATA_W-1:0] wdata_dbg,
    input  logic              we_gc,
    input  logic              we_lc,
    input  logic              we_dbg,
    output logic              gnt_gc,
    output logic              gnt_lc,
    output logic              gnt_dbg,
    output logic              rvalid_gc,
    output logic              rvalid_lc,
    output logic              rvalid_dbg,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state_q, state_d;
    logic       pend_q, pend_d;
    logic       pref_lc_q, pref_lc_d;

    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [NUM_REQ-1:0] req_v, we_v, gnt;
    logic [ADDR_W-1:0]  addr_v  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_v [NUM_REQ];
    logic               own_req;

    logic              clr_start, clr_busy, clr_last;
    logic [ADDR_W-1:0] clr_addr;

    // Read data goes straight from the memory to the requesters.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;

    assign req_v = {req_dbg, req_lc, req_gc};
    assign we_v  = {we_dbg, we_lc, we_gc};

    assign addr_v[GC]   = addr_gc;
    assign addr_v[LC]   = addr_lc;
    assign addr_v[DBG]  = addr_dbg;
    assign wdata_v[GC]  = wdata_gc;
    assign wdata_v[LC]  = wdata_lc;
    assign wdata_v[DBG] = wdata_dbg;

    assign gnt[GC]  = (state_q == StOwnGc);
    assign gnt[LC]  = (state_q == StOwnLc);
    assign gnt[DBG] = (state_q == StOwnDbg);
    assign own_req  = |(gnt & req_v);

    assign gnt_gc     = gnt[GC];
    assign gnt_lc     = gnt[LC];
    assign gnt_dbg    = gnt[DBG];
    assign rvalid_gc  = rvalid_q[GC];
    assign rvalid_lc  = rvalid_q[LC];
    assign rvalid_dbg = rvalid_q[DBG];
    assign clear_busy = clr_busy;

    grid_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk_i   (clk),
        .rst_i   (reset),
        .start_i (clr_start),
        .busy_o  (clr_busy),
        .addr_o  (clr_addr),
        .last_o  (clr_last)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        pref_lc_d = pref_lc_q;
        clr_start = 1'b0;
        case (state_q)
            StClear: begin
                if (clr_last) state_d = StIdle;
            end
            StIdle: begin
                if (clear_start || pend_q) begin
                    state_d   = StClear;
                    clr_start = 1'b1;
                    pend_d    = 1'b0;
                end else if (req_dbg) begin
                    state_d = StOwnDbg;
                end else if (req_gc && (!req_lc || !pref_lc_q)) begin
                    state_d   = StOwnGc;
                    pref_lc_d = 1'b1;
                end else if (req_lc) begin
                    state_d   = StOwnLc;
                    pref_lc_d = 1'b0;
                end
            end
            StOwnGc, StOwnLc, StOwnDbg: begin
                // The owner is never preempted; a clear waits for the release.
                if (clear_start) pend_d = 1'b1;
                if (!own_req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rvalid_d = gnt & req_v & ~we_v;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (state_q == StClear) begin
                mem_we   = 1'b1;
                mem_addr = clr_addr;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gnt[i] && req_v[i]) begin
                        mem_we    = we_v[i];
                        mem_addr  = addr_v[i];
                        mem_wdata = wdata_v[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClear;
            pend_q    <= 1'b0;
            pref_lc_q <= 1'b0;
            rvalid_q  <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pref_lc_q <= pref_lc_d;
            rvalid_q  <= rvalid_d;
        end
    end

endmodule
